decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Registered, handshaked RV32I decode stage between fetch and execute. Extends the flat
//  combinational decoder to R, I-ALU, load, store, branch, JAL, JALR and LUI. Adds immediate
//  generation, register-index extraction and an illegal-instruction flag. Holds one decoded
//  instruction in a valid/ready pipeline register with flush support.
// PARAMETERS
//  XLEN      32  datapath width; imm sign-extended to XLEN, pc is XLEN wide (XLEN>=32)
//  ALUOP_W   4   alu_op width; encoding {funct7[5],funct3}, must be >=4
// PORTS
//  clk         in   1         rising-edge clock
//  rst         in   1         async active-high reset
//  flush       in   1         discard held and incoming instruction (sync)
//  in_valid    in   1         fetch presents instr/pc
//  in_ready    out  1         stage can accept this cycle
//  instr       in   32        raw instruction
//  pc_in       in   XLEN      instruction address
//  out_valid   out  1         decoded bundle valid
//  out_ready   in   1         execute accepts bundle
//  pc_out      out  XLEN      registered pc
//  rs1,rs2,rd  out  5 each    register indices (rd=0 when no writeback)
//  imm         out  XLEN      sign-extended immediate (I/S/B/U/J by format, else 0)
//  alu_op      out  ALUOP_W   ALU operation
//  reg_write, mem_read, mem_write, mem_to_reg, branch, jump  out 1 each  control
//  illegal     out  1         unsupported opcode/funct; all controls forced 0
// BEHAVIOUR
//  - rst asserted: out_valid=0, every output=0 immediately (async); released sync to clk
//  - in_ready = !out_valid | out_ready (combinational); load when in_valid&in_ready
//  - latency 1: bundle appears the cycle after acceptance; full throughput with out_ready=1
//  - out_valid&!out_ready: all outputs stable, held until accepted
//  - accepted and no new load: out_valid->0; bundle outputs keep last value
//  - flush (priority over load): out_valid->0 next edge; a same-cycle in_valid is dropped
//    even though in_ready is 1
//  - decode (opcode = instr[6:0], f3 = [14:12], f7b5 = [30]):
//    0110011 R:     alu_op={f7b5,f3}; reg_write; legal only if f7 in {0x00,0x20},
//                   and 0x20 only with f3 000/101
//    0010011 I-ALU: alu_op={0,f3}, except f3=101 -> {f7b5,101}; reg_write; imm=I
//    0000011 load:  alu_op=0000; reg_write,mem_read,mem_to_reg; imm=I; legal f3 000/001/010/100/101
//    0100011 store: alu_op=0000; mem_write; rd=0; imm=S; legal f3 000/001/010
//    1100011 B:     alu_op=1000 (sub); branch; rd=0; imm=B; f3 010/011 illegal
//    1101111 JAL:   jump, reg_write; imm=J
//    1100111 JALR:  jump, reg_write, alu_op=0000; imm=I; f3 must be 000
//    0110111 LUI:   reg_write, alu_op=0000; rs1=0; imm=U
//    other:         illegal=1
//  - illegal: bundle still valid; all controls 0; rd=0
//  - reg_write forced 0 when rd==0
//  - rs2 = instr[24:20] for R/S/B only, else 0; rs1 = 0 for JAL/LUI
//  - imm sign bit is instr[31], replicated to XLEN; B/J low bit is 0
// TESTING
//  1. instr=0x40B50533 (sub a0,a0,a1), out_ready=1 -> next cycle out_valid=1, alu_op=1000,
//     rs1=10, rs2=11, rd=10, reg_write=1
//  2. lw 0x00452283, XLEN=64 -> imm=4, mem_read=mem_to_reg=reg_write=1, alu_op=0000;
//     instr 0xFFC52283 -> imm=0xFFFFFFFFFFFFFFFC
//  3. beq 0xFE000EE3 -> branch=1, rd=0, imm=-4, alu_op=1000; instr 0x0000007F -> illegal=1,
//     controls 0
//  4. out_ready=0 with 3 back-to-back in_valid -> first bundle held stable, in_ready=0;
//     release -> remaining 2 emerge in order, none lost or duplicated
//  5. flush with in_valid=1 and a held bundle -> out_valid=0 next cycle, dropped instr never appears
//  6. rst pulsed mid-stream between clk edges -> out_valid and outputs 0 immediately;
//     first accept after release decodes correctly

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode stage sitting between fetch and execute.
// Decodes R, I-ALU, load, store, branch, JAL, JALR and LUI into register indices,
// a sign-extended immediate, an ALU op and control strobes, and holds one decoded
// bundle in a valid/ready pipeline register with a synchronous flush.
//
// Handshake: a transfer happens on a rising edge where the sender's valid and the
// receiver's ready are both high. Valid never depends on ready; once valid is
// raised, the payload stays stable until the transfer. Here in_ready is
// !out_valid | out_ready, so the held bundle drains and a new one loads on the
// same edge. Flush overrides everything: the held bundle is discarded and an
// instruction presented in the same cycle is dropped even though in_ready is 1.
module decode_stage #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        instr,
    input  logic [XLEN-1:0]    pc_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    pc_out,
    output logic [4:0]         rs1,
    output logic [4:0]         rs2,
    output logic [4:0]         rd,
    output logic [XLEN-1:0]    imm,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               reg_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               branch,
    output logic               jump,
    output logic               illegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // Immediate layout selected by the instruction format.
    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_sel_e;

    // Instruction fields.
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Classification results (before illegal masking).
    logic       legal;
    imm_sel_e   imm_sel;
    logic       use_rs1;
    logic       use_rs2;
    logic       use_rd;
    logic [3:0] alu4;
    logic       ctl_reg_write;
    logic       ctl_mem_read;
    logic       ctl_mem_write;
    logic       ctl_mem_to_reg;
    logic       ctl_branch;
    logic       ctl_jump;

    // Raw 32-bit sign-extended immediate.
    logic [31:0] imm32;

    // Next-state bundle.
    logic [XLEN-1:0]    pc_d;
    logic [4:0]         rs1_d;
    logic [4:0]         rs2_d;
    logic [4:0]         rd_d;
    logic [XLEN-1:0]    imm_d;
    logic [ALUOP_W-1:0] alu_op_d;
    logic               reg_write_d;
    logic               mem_read_d;
    logic               mem_write_d;
    logic               mem_to_reg_d;
    logic               branch_d;
    logic               jump_d;
    logic               illegal_d;

    // Registered bundle.
    logic               valid_q;
    logic [XLEN-1:0]    pc_q;
    logic [4:0]         rs1_q;
    logic [4:0]         rs2_q;
    logic [4:0]         rd_q;
    logic [XLEN-1:0]    imm_q;
    logic [ALUOP_W-1:0] alu_op_q;
    logic               reg_write_q;
    logic               mem_read_q;
    logic               mem_write_q;
    logic               mem_to_reg_q;
    logic               branch_q;
    logic               jump_q;
    logic               illegal_q;

    logic load;

    assign in_ready = !valid_q || out_ready;
    assign load     = in_valid && in_ready && !flush;

    // Opcode/funct classification: legality, operand usage, ALU op and controls.
    always_comb begin
        legal          = 1'b0;
        imm_sel        = IMM_NONE;
        use_rs1        = 1'b0;
        use_rs2        = 1'b0;
        use_rd         = 1'b0;
        alu4           = 4'b0000;
        ctl_reg_write  = 1'b0;
        ctl_mem_read   = 1'b0;
        ctl_mem_write  = 1'b0;
        ctl_mem_to_reg = 1'b0;
        ctl_branch     = 1'b0;
        ctl_jump       = 1'b0;
        case (opcode)
            OP_R: begin
                // funct7 0x20 only selects SUB and SRA.
                legal = (funct7 == 7'h00) ||
                        ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                use_rd        = 1'b1;
                alu4          = {funct7[5], funct3};
                ctl_reg_write = 1'b1;
            end
            OP_IMM: begin
                // Only the right-shift pair uses bit 30 to pick SRLI/SRAI.
                legal         = 1'b1;
                use_rs1       = 1'b1;
                use_rd        = 1'b1;
                alu4          = (funct3 == 3'b101) ? {funct7[5], funct3} : {1'b0, funct3};
                ctl_reg_write = 1'b1;
                imm_sel       = IMM_I;
            end
            OP_LOAD: begin
                legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                        (funct3 == 3'b100) || (funct3 == 3'b101);
                use_rs1        = 1'b1;
                use_rd         = 1'b1;
                ctl_reg_write  = 1'b1;
                ctl_mem_read   = 1'b1;
                ctl_mem_to_reg = 1'b1;
                imm_sel        = IMM_I;
            end
            OP_STORE: begin
                legal         = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                ctl_mem_write = 1'b1;
                imm_sel       = IMM_S;
            end
            OP_BRANCH: begin
                legal      = (funct3 != 3'b010) && (funct3 != 3'b011);
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
                alu4       = 4'b1000;
                ctl_branch = 1'b1;
                imm_sel    = IMM_B;
            end
            OP_JAL: begin
                legal         = 1'b1;
                use_rd        = 1'b1;
                ctl_jump      = 1'b1;
                ctl_reg_write = 1'b1;
                imm_sel       = IMM_J;
            end
            OP_JALR: begin
                legal         = (funct3 == 3'b000);
                use_rs1       = 1'b1;
                use_rd        = 1'b1;
                ctl_jump      = 1'b1;
                ctl_reg_write = 1'b1;
                imm_sel       = IMM_I;
            end
            OP_LUI: begin
                legal         = 1'b1;
                use_rd        = 1'b1;
                ctl_reg_write = 1'b1;
                imm_sel       = IMM_U;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    // Immediate assembly; instr[31] is always the sign bit, B/J have bit 0 clear.
    always_comb begin
        imm32 = 32'd0;
        case (imm_sel)
            IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            IMM_U: imm32 = {instr[31:12], 12'd0};
            IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
    end

    // Bundle assembly: an illegal instruction carries only its pc and the flag.
    always_comb begin
        pc_d         = pc_in;
        rs1_d        = (legal && use_rs1) ? instr[19:15] : 5'd0;
        rs2_d        = (legal && use_rs2) ? instr[24:20] : 5'd0;
        rd_d         = (legal && use_rd)  ? instr[11:7]  : 5'd0;
        imm_d        = legal ? XLEN'($signed(imm32)) : '0;
        alu_op_d     = legal ? ALUOP_W'(alu4) : '0;
        // Writing x0 is a no-op, so do not advertise a writeback for it.
        reg_write_d  = legal && ctl_reg_write && (rd_d != 5'd0);
        mem_read_d   = legal && ctl_mem_read;
        mem_write_d  = legal && ctl_mem_write;
        mem_to_reg_d = legal && ctl_mem_to_reg;
        branch_d     = legal && ctl_branch;
        jump_d       = legal && ctl_jump;
        illegal_d    = !legal;
    end

    // Valid flag: flush clears, load sets, a drain with no refill clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Bundle payload: only changes on a load, so it holds while stalled or idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            imm_q        <= '0;
            alu_op_q     <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            branch_q     <= 1'b0;
            jump_q       <= 1'b0;
            illegal_q    <= 1'b0;
        end else if (load) begin
            pc_q         <= pc_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
            imm_q        <= imm_d;
            alu_op_q     <= alu_op_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            branch_q     <= branch_d;
            jump_q       <= jump_d;
            illegal_q    <= illegal_d;
        end
    end

    assign out_valid  = valid_q;
    assign pc_out     = pc_q;
    assign rs1        = rs1_q;
    assign rs2        = rs2_q;
    assign rd         = rd_q;
    assign imm        = imm_q;
    assign alu_op     = alu_op_q;
    assign reg_write  = reg_write_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_to_reg = mem_to_reg_q;
    assign branch     = branch_q;
    assign jump       = jump_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage (XLEN=64).
module tb_decode_stage;

    localparam int XLEN    = 64;
    localparam int ALUOP_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        instr;
    logic [XLEN-1:0]    pc_in;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    pc_out;
    logic [4:0]         rs1, rs2, rd;
    logic [XLEN-1:0]    imm;
    logic [ALUOP_W-1:0] alu_op;
    logic               reg_write, mem_read, mem_write, mem_to_reg, branch, jump, illegal;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [4:0]         rd;
        logic [XLEN-1:0]    imm;
        logic [ALUOP_W-1:0] alu_op;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               branch;
        logic               jump;
        logic               illegal;
    } bundle_t;

    bundle_t exp_q[$];

    decode_stage #(.XLEN(XLEN), .ALUOP_W(ALUOP_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc_in(pc_in),
        .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .alu_op(alu_op),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .branch(branch), .jump(jump), .illegal(illegal)
    );

    // Clock.
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Sign-extend the low 'bits' bits of v to XLEN.
    function automatic logic [XLEN-1:0] sx(input logic [31:0] v, input int bits);
        logic signed [XLEN-1:0] t;
        t = $signed({32'd0, v} << (XLEN - bits));
        return t >>> (XLEN - bits);
    endfunction

    function automatic bundle_t ref_decode(input logic [31:0] i, input logic [XLEN-1:0] pc);
        bundle_t    b;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       ok;
        f3 = i[14:12];
        f7 = i[31:25];
        b = '0;
        b.pc = pc;
        ok = 1'b1;
        case (i[6:0])
            7'h33: begin
                ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                b.rs1 = i[19:15]; b.rs2 = i[24:20]; b.rd = i[11:7];
                b.alu_op = {i[30], f3}; b.reg_write = 1'b1;
            end
            7'h13: begin
                b.rs1 = i[19:15]; b.rd = i[11:7]; b.imm = sx(i[31:20], 12);
                b.alu_op = (f3 == 3'd5) ? {i[30], f3} : {1'b0, f3}; b.reg_write = 1'b1;
            end
            7'h03: begin
                ok = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
                b.rs1 = i[19:15]; b.rd = i[11:7]; b.imm = sx(i[31:20], 12);
                b.reg_write = 1'b1; b.mem_read = 1'b1; b.mem_to_reg = 1'b1;
            end
            7'h23: begin
                ok = (f3 <= 3'd2);
                b.rs1 = i[19:15]; b.rs2 = i[24:20];
                b.imm = sx({i[31:25], i[11:7]}, 12); b.mem_write = 1'b1;
            end
            7'h63: begin
                ok = (f3 != 3'd2) && (f3 != 3'd3);
                b.rs1 = i[19:15]; b.rs2 = i[24:20]; b.alu_op = 4'b1000; b.branch = 1'b1;
                b.imm = sx({19'd0, i[31], i[7], i[30:25], i[11:8], 1'b0}, 13);
            end
            7'h6F: begin
                b.rd = i[11:7]; b.jump = 1'b1; b.reg_write = 1'b1;
                b.imm = sx({11'd0, i[31], i[19:12], i[20], i[30:21], 1'b0}, 21);
            end
            7'h67: begin
                ok = (f3 == 3'd0);
                b.rs1 = i[19:15]; b.rd = i[11:7]; b.imm = sx(i[31:20], 12);
                b.jump = 1'b1; b.reg_write = 1'b1;
            end
            7'h37: begin
                b.rd = i[11:7]; b.reg_write = 1'b1; b.imm = sx({i[31:12], 12'd0}, 32);
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            b = '0;
            b.pc = pc;
            b.illegal = 1'b1;
        end
        if (b.rd == 5'd0) b.reg_write = 1'b0;
        return b;
    endfunction

    function automatic bundle_t observed();
        bundle_t b;
        b.pc = pc_out; b.rs1 = rs1; b.rs2 = rs2; b.rd = rd; b.imm = imm; b.alu_op = alu_op;
        b.reg_write = reg_write; b.mem_read = mem_read; b.mem_write = mem_write;
        b.mem_to_reg = mem_to_reg; b.branch = branch; b.jump = jump; b.illegal = illegal;
        return b;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  ops [8];
        int          k;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37};
        r = $urandom;
        k = $urandom_range(0, 11);
        if (k < 8) begin
            r[6:0] = ops[k];
            if ($urandom_range(0, 3) == 0) r[11:7] = 5'd0;
            if ((k == 0 || k == 1) && $urandom_range(0, 3) != 0)
                r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            if (k == 6 && $urandom_range(0, 3) != 0) r[14:12] = 3'd0;
        end else if (k < 10) begin
            r[6:0] = 7'h7F;
        end
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction with out_ready=1; returns 1ns after the accepting edge.
    task automatic send_one(input logic [31:0] i, input logic [XLEN-1:0] pc);
        in_valid  = 1'b1;
        instr     = i;
        pc_in     = pc;
        out_ready = 1'b1;
        flush     = 1'b0;
        tick();
        in_valid  = 1'b0;
    endtask

    // Streams n random instructions; compares each cycle at the negedge.
    task automatic run_stream(input int n, input int valid_pct, input int ready_pct,
                              input int flush_pct, input int stall, input string tag,
                              output int cycles);
        int              sent;
        int              cyc;
        bit              have;
        bit              exp_ready;
        logic [31:0]     cur;
        logic [XLEN-1:0] cur_pc;
        sent = 0; cyc = 0; have = 1'b0; cur = '0; cur_pc = '0;
        while ((sent < n || exp_q.size() != 0) && cyc < n * 20 + 100) begin
            if (!have && sent < n && $urandom_range(1, 100) <= valid_pct) begin
                cur    = rand_instr();
                cur_pc = {$urandom, $urandom} & ~64'd3;
                have   = 1'b1;
            end
            in_valid  = have;
            instr     = have ? cur : $urandom;
            pc_in     = cur_pc;
            out_ready = (cyc >= stall) && ($urandom_range(1, 100) <= ready_pct);
            flush     = ($urandom_range(1, 100) <= flush_pct);
            @(negedge clk);
            exp_ready = (exp_q.size() == 0) || out_ready;
            total++;
            if (out_valid !== (exp_q.size() != 0)) begin
                bad++;
                $display("FAIL %s out_valid cyc=%0d got=%b exp=%b", tag, cyc, out_valid, exp_q.size() != 0);
            end
            total++;
            if (in_ready !== exp_ready) begin
                bad++;
                $display("FAIL %s in_ready cyc=%0d got=%b exp=%b", tag, cyc, in_ready, exp_ready);
            end
            if (exp_q.size() != 0) begin
                total++;
                if (observed() !== exp_q[0]) begin
                    bad++;
                    $display("FAIL %s bundle cyc=%0d got=%h exp=%h", tag, cyc, observed(), exp_q[0]);
                end
                if (out_ready || flush) void'(exp_q.pop_front());
            end
            if (have && (flush || exp_ready)) begin
                if (!flush) exp_q.push_back(ref_decode(cur, cur_pc));
                sent++;
                have = 1'b0;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        cycles   = cyc;
        total++;
        if (sent < n || exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s timeout sent=%0d pending=%0d exp_sent=%0d", tag, sent, exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; pc_in = '0;
        tick(); tick();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++;
        if (observed() !== bundle_t'(0)) begin bad++; $display("FAIL reset_bundle got=%h exp=0", observed()); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_r_type();
        send_one(32'h40B50533, 64'h100);
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL sub_valid got=%b exp=1", out_valid); end
        total++;
        if ({alu_op, rs1, rs2, rd, reg_write} !== {4'b1000, 5'd10, 5'd11, 5'd10, 1'b1}) begin
            bad++;
            $display("FAIL sub_fields got=%h/%0d/%0d/%0d/%b exp=8/10/11/10/1", alu_op, rs1, rs2, rd, reg_write);
        end
        total++;
        if (observed() !== ref_decode(32'h40B50533, 64'h100)) begin
            bad++; $display("FAIL sub_bundle got=%h exp=%h", observed(), ref_decode(32'h40B50533, 64'h100));
        end
        tick();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL sub_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_load();
        send_one(32'h00452283, 64'h104);
        total++;
        if ({imm, mem_read, mem_to_reg, reg_write, alu_op} !== {64'd4, 3'b111, 4'b0000}) begin
            bad++;
            $display("FAIL lw_pos got=%h/%b%b%b/%h exp=4/111/0", imm, mem_read, mem_to_reg, reg_write, alu_op);
        end
        send_one(32'hFFC52283, 64'h108);
        total++;
        if (imm !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            bad++; $display("FAIL lw_neg_imm got=%h exp=fffffffffffffffc", imm);
        end
        total++;
        if (observed() !== ref_decode(32'hFFC52283, 64'h108)) begin
            bad++; $display("FAIL lw_neg_bundle got=%h exp=%h", observed(), ref_decode(32'hFFC52283, 64'h108));
        end
        tick();
    endtask

    task automatic test_branch_illegal();
        send_one(32'hFE000EE3, 64'h10C);
        total++;
        if ({branch, rd, imm, alu_op} !== {1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFC, 4'b1000}) begin
            bad++; $display("FAIL beq got=%b/%0d/%h/%h exp=1/0/fffffffffffffffc/8", branch, rd, imm, alu_op);
        end
        send_one(32'h0000007F, 64'h110);
        total++;
        if ({out_valid, illegal} !== 2'b11) begin
            bad++; $display("FAIL illegal_flag got=%b%b exp=11", out_valid, illegal);
        end
        total++;
        if ({reg_write, mem_read, mem_write, mem_to_reg, branch, jump, rd} !== 11'd0) begin
            bad++;
            $display("FAIL illegal_ctl got=%b%b%b%b%b%b rd=%0d exp=0", reg_write, mem_read, mem_write,
                     mem_to_reg, branch, jump, rd);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int cycles;
        run_stream(3, 100, 100, 0, 5, "b2b_stall", cycles);
        run_stream(20, 100, 100, 0, 0, "throughput", cycles);
        total++;
        if (cycles != 21) begin bad++; $display("FAIL throughput_cycles got=%0d exp=21", cycles); end
    endtask

    task automatic test_flush();
        in_valid = 1'b1; instr = 32'h00100093; pc_in = 64'h200; out_ready = 1'b0; flush = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_held got=%b exp=1", out_valid); end
        instr = 32'h00200113; pc_in = 64'h204; out_ready = 1'b1; flush = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_drop k=%0d got=%b exp=0", k, out_valid); end
            tick();
        end
    endtask

    task automatic test_reset_midstream();
        in_valid = 1'b1; instr = 32'h40B50533; pc_in = 64'h300; out_ready = 1'b0; flush = 1'b0;
        tick();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
        total++;
        if (observed() !== bundle_t'(0)) begin bad++; $display("FAIL midrst_bundle got=%h exp=0", observed()); end
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        send_one(32'h123452B7, 64'h304);
        total++;
        if ({out_valid, imm, rd, rs1, reg_write} !== {1'b1, 64'h12345000, 5'd5, 5'd0, 1'b1}) begin
            bad++; $display("FAIL lui_after_rst got=%b/%h/%0d/%0d/%b exp=1/12345000/5/0/1",
                            out_valid, imm, rd, rs1, reg_write);
        end
        total++;
        if (observed() !== ref_decode(32'h123452B7, 64'h304)) begin
            bad++; $display("FAIL lui_bundle got=%h exp=%h", observed(), ref_decode(32'h123452B7, 64'h304));
        end
        tick();
    endtask

    task automatic test_random();
        int cycles;
        run_stream(300, 80, 70, 5, 0, "random", cycles);
        run_stream(100, 100, 40, 0, 0, "random_bp", cycles);
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_load();
        test_branch_illegal();
        test_back_to_back();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
